uart_rx: RTL and testbench

- Asynchronous serial receiver: 8N1 (optionally 8E1) frames arrive on a single line and are presented as parallel bytes over a valid/ready handshake.
- Pairs with the team's serial transmitter as the receiving end of the same link.
- Sits between the board RX pin and the command/data consumer logic.
- Includes an input synchronizer, mid-bit sampling, framing check and overrun detection.

---
 rtl/uart_rx.sv | 163 ++++++++++++++++
 tb/tb_uart_rx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, valid/ready byte output.
// Define UART_RX_PARITY_EN for 8E1 with a parity_err pulse.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 framing_err,
  output logic                 overrun_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST    = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                 state;
  logic                   s1;
  logic                   rx_s;
  logic                   armed;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shift;
  logic                   par_bit;

  // two-flop synchronizer, resets to line-idle
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1   <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      s1   <= rx;
      rx_s <= s1;
    end
  end

  // frame FSM, output registers and handshake
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      par_bit     <= 1'b0;
      armed       <= 1'b1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
      busy        <= 1'b0;
    end else begin
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
      if (rx_s)
        armed <= 1'b1;
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          cnt  <= '0;
          if (!rx_s && armed) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST)
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= ^{shift, par_bit};
`endif
            if (rx_s) begin
              rx_data     <= shift;
              rx_valid    <= 1'b1;
              overrun_err <= rx_valid && !rx_ready;
            end else begin
              framing_err <= 1'b1;
              armed       <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  wire unused_ok = ^{par_bit, bit_idx};

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with hand-computed results.
// CLKS_PER_BIT=16, DATA_BITS=8.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + CPB / 2 + 10 * CPB;
`else
  localparam int LAT = 2 + CPB / 2 + 9 * CPB;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       framing_err;
  logic       overrun_err;
  logic       parity_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int fe_n = 0, ov_n = 0, pe_n = 0, vr_n = 0, vh_n = 0, bz_n = 0;
  logic pv = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .framing_err(framing_err),
    .overrun_err(overrun_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy(busy)
  );

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always #5 clk = ~clk;

  // event counters sampled away from the active edge
  always @(negedge clk) begin
    if (framing_err) fe_n++;
    if (overrun_err) ov_n++;
    if (parity_err) pe_n++;
    if (rx_valid) vh_n++;
    if (busy) bz_n++;
    if (rx_valid && !pv) vr_n++;
    pv = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_tx(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stopb,
                      input logic par);
    @(posedge clk);
    #1;
    bit_tx(1'b0);
    for (int i = 0; i < 8; i++) bit_tx(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_tx(par);
`endif
    bit_tx(stopb);
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  int lat, b_fe, b_ov, b_vr, b_vh, b_bz, b_pe;

  initial begin
    rst = 1'b0;
    rx = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", 32'(rx_data), 32'h0);
    chk("rst_valid", 32'(rx_valid), 32'h0);
    chk("rst_fe", 32'(framing_err), 32'h0);
    chk("rst_ov", 32'(overrun_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_pe", 32'(parity_err), 32'h0);
    rst = 1'b1;
    repeat (4) @(posedge clk);

    // good frame 0xA5 with ready high
    rx_ready = 1'b1;
    b_fe = fe_n; b_vh = vh_n;
    lat = -1;
    fork
      send(8'hA5, 1'b1, 1'b0);
      begin
        @(posedge clk);
        #1;
        for (int n = 1; n <= 250; n++) begin
          @(negedge clk);
          if (rx_valid) begin
            lat = n - 1;
            break;
          end
        end
      end
    join
    chk("good_data", 32'(rx_data), 32'hA5);
    chk("good_lat_ok", 32'(lat >= LAT - 1 && lat <= LAT + 1), 32'h1);
    chk("good_vhigh", 32'(vh_n - b_vh), 32'h1);
    chk("good_fe", 32'(fe_n - b_fe), 32'h0);

    // glitch: 5 low cycles
    b_bz = bz_n; b_vr = vr_n; b_fe = fe_n;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy", 32'(bz_n - b_bz), 32'd8);
    chk("glitch_vr", 32'(vr_n - b_vr), 32'h0);
    chk("glitch_fe", 32'(fe_n - b_fe), 32'h0);

    // framing error then a good frame
    b_vr = vr_n; b_fe = fe_n;
    send(8'h3C, 1'b0, 1'b0);
    chk("frm_fe", 32'(fe_n - b_fe), 32'h1);
    chk("frm_vr", 32'(vr_n - b_vr), 32'h0);
    send(8'h55, 1'b1, 1'b0);
    chk("frm_next_data", 32'(rx_data), 32'h55);
    chk("frm_next_vr", 32'(vr_n - b_vr), 32'h1);
    chk("frm_next_fe", 32'(fe_n - b_fe), 32'h1);

    // overrun
    rx_ready = 1'b0;
    b_ov = ov_n;
    send(8'h11, 1'b1, 1'b0);
    chk("ovr_first", 32'(rx_data), 32'h11);
    chk("ovr_none_yet", 32'(ov_n - b_ov), 32'h0);
    send(8'h22, 1'b1, 1'b0);
    @(negedge clk);
    chk("ovr_data", 32'(rx_data), 32'h22);
    chk("ovr_valid", 32'(rx_valid), 32'h1);
    chk("ovr_pulse", 32'(ov_n - b_ov), 32'h1);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(negedge clk);
    chk("ovr_hold", 32'(rx_valid), 32'h1);
    @(negedge clk);
    chk("ovr_clear", 32'(rx_valid), 32'h0);

    // reset in the middle of DATA bit 3 of 0xFF
    rx_ready = 1'b0;
    send(8'h5A, 1'b1, 1'b0);
    chk("pre_valid", 32'(rx_valid), 32'h1);
    fork
      send(8'hFF, 1'b1, 1'b0);
      begin
        repeat (66) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_data", 32'(rx_data), 32'h0);
        chk("mid_valid", 32'(rx_valid), 32'h0);
        chk("mid_busy", 32'(busy), 32'h0);
        chk("mid_errs", 32'({framing_err, overrun_err}), 32'h0);
        b_vr = vr_n;
        b_bz = bz_n;
      end
    join
    chk("mid_tail_vr", 32'(vr_n - b_vr), 32'h0);
    chk("mid_tail_busy", 32'(bz_n - b_bz), 32'h0);
    rx_ready = 1'b1;
    send(8'h81, 1'b1, 1'b0);
    chk("post_rst_data", 32'(rx_data), 32'h81);
    chk("post_rst_vr", 32'(vr_n - b_vr), 32'h1);

`ifdef UART_RX_PARITY_EN
    b_pe = pe_n; b_vr = vr_n;
    send(8'h07, 1'b1, 1'b0);
    chk("par_bad_pe", 32'(pe_n - b_pe), 32'h1);
    chk("par_bad_data", 32'(rx_data), 32'h07);
    chk("par_bad_vr", 32'(vr_n - b_vr), 32'h1);
    b_pe = pe_n;
    send(8'h07, 1'b1, 1'b1);
    chk("par_good_pe", 32'(pe_n - b_pe), 32'h0);
    chk("par_good_vr", 32'(vr_n - b_vr), 32'h2);
`else
    b_pe = pe_n;
    chk("no_par_pe", 32'(b_pe), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
